// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction ROM port, hazard/redirect controls and IF/ID outputs.
// The master modport is the fetch stage; the slave modport is the surrounding pipeline.
interface instruction_fetch_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            stall;
  logic            flush;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            exception;
  logic            irq;
  logic [XLEN-1:0] if_id_instr;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic            if_id_valid;
  logic            irq_ack;
  logic [XLEN-1:0] epc;

  modport master (
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, irq_ack, epc,
    input  imem_instr, stall, flush, branch_taken, branch_target,
           jump, jump_target, exception, irq
  );

  modport slave (
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, irq_ack, epc,
    output imem_instr, stall, flush, branch_taken, branch_target,
           jump, jump_target, exception, irq
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, arbitrates next-PC, fills IF/ID and records EPC.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] INTR_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXCP_VECTOR = 32'h8000_0008
) (
  input  logic                clk,
  input  logic                reset_n,
  instruction_fetch_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        irq_ok;
  logic        redirect;

  // Bit 31 is the supervisor flag, so sequential flow never changes mode.
  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

  // A masked or collided request simply waits: irq is level-sensitive.
  assign irq_ok   = bus.irq & ~pc[31] & ~bus.branch_taken & ~bus.jump & ~bus.stall;
  assign redirect = bus.exception | irq_ok | bus.branch_taken | bus.jump;

  assign bus.imem_addr = pc;

  always_comb begin
    pc_next = pc_plus4;
    if (bus.exception)         pc_next = EXCP_VECTOR;
    else if (irq_ok)           pc_next = INTR_VECTOR;
    else if (bus.branch_taken) pc_next = bus.branch_target;
    else if (bus.jump)         pc_next = bus.jump_target;
    else if (bus.stall)        pc_next = pc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= RESET_PC;
    else          pc <= pc_next;
  end

  // Any redirect squashes the word currently being fetched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.if_id_instr    <= '0;
      bus.if_id_pc_plus4 <= '0;
      bus.if_id_valid    <= 1'b0;
    end else if (redirect || bus.flush) begin
      bus.if_id_instr    <= '0;
      bus.if_id_pc_plus4 <= '0;
      bus.if_id_valid    <= 1'b0;
    end else if (!bus.stall) begin
      bus.if_id_instr    <= bus.imem_instr;
      bus.if_id_pc_plus4 <= pc_plus4;
      bus.if_id_valid    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.epc     <= '0;
      bus.irq_ack <= 1'b0;
    end else begin
      bus.irq_ack <= irq_ok & ~bus.exception;
      if (bus.exception || irq_ok) bus.epc <= pc_plus4;
    end
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the five-stage MIPS pipeline. Owns the program counter and drives the address of the combinational instruction ROM. Captures the returned word into the IF/ID pipeline register. Arbitrates next-PC among reset, exception, interrupt, branch, jump, stall and sequential flow, and produces the EPC value consumed by writeback for `$k0`.

## Interface
- `RESET_PC`, 32'h80000000, PC loaded on reset (bit 31 = supervisor)
- `INTR_VECTOR`, 32'h80000004, interrupt entry
- `EXCP_VECTOR`, 32'h80000008, exception entry
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `imem_addr`  out  32  current PC to instruction ROM
- `imem_instr`  in  32  ROM data, combinational from `imem_addr`
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `flush`  in  1  hazard unit: load bubble into IF/ID
- `branch_taken`  in  1  EX-stage branch resolved taken
- `branch_target`  in  32  branch destination
- `jump`  in  1  ID-stage j/jal/jr/jalr
- `jump_target`  in  32  jump destination
- `exception`  in  1  undefined-instruction trap from ID
- `irq`  in  1  level interrupt request, synchronous to `clk`
- `if_id_instr`  out  32  registered instruction
- `if_id_pc_plus4`  out  32  registered PC+4
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `irq_ack`  out  1  one-cycle pulse, interrupt accepted
- `epc`  out  32  return address (squashed PC + 4), held until next entry

## Operation
- `pc_plus4 = {pc[31], pc[30:0] + 31'd4}`. Bit 31 is preserved, and the lower 31 bits wrap modulo 2^31.
- `imem_addr = pc` continuously. The ROM indexes `pc[9:2]`, so bit 31 is ignored by memory.
- `irq_ok = irq & ~pc[31] & ~branch_taken & ~jump & ~stall`. Interrupts are masked in supervisor mode. A request that arrives with a redirect or stall is deferred, not lost, because `irq` is a level signal.
- Next-PC priority, first match wins:
  1. `exception` -> `EXCP_VECTOR`
  2. `irq_ok` -> `INTR_VECTOR`
  3. `branch_taken` -> `branch_target`
  4. `jump` -> `jump_target`
  5. `stall` -> `pc` (hold)
  6. otherwise -> `pc_plus4`
- IF/ID update, first match wins:
  - Cases 1–4 above, or `flush`: load bubble (`instr` = 0, `pc_plus4` = 0, `valid` = 0).
  - Otherwise `stall`: hold IF/ID.
  - Otherwise: load `imem_instr`, `pc_plus4`, `valid` = 1.
- `branch_taken` with `jump` in the same cycle: the branch wins, because it is the older instruction.
- `flush` with `stall`: IF/ID takes the bubble and PC holds.
- On `irq_ok`:
  - `epc <= pc_plus4` of the squashed fetch, so the handler's `$k0 - 4` resumes at that PC.
  - `irq_ack <= 1` for exactly one cycle.
- On `exception`: `epc <= pc_plus4`, and `irq_ack` stays 0.
- Leaving supervisor mode happens only through a redirect (jr `$k0`) whose target has bit 31 = 0.

## Timing
- Reset (`reset_n` low, asynchronous, takes effect immediately):
  - `pc` = `RESET_PC`
  - `if_id_instr` = 0, `if_id_pc_plus4` = 0, `if_id_valid` = 0
  - `irq_ack` = 0, `epc` = 0
- After reset deassertion, the first rising edge captures `ROM[RESET_PC]` into IF/ID with `valid` = 1.
- Fetch latency is one cycle: the instruction at PC appears on `if_id_instr` after the edge following PC presentation.
- All control inputs are sampled on the rising edge. A redirect updates `pc` on that edge, and the target instruction reaches IF/ID one edge later, giving one bubble.
- A stall held for N cycles freezes `pc` and IF/ID for N edges, with no skipped or duplicated fetch.
- Reset mid-operation discards the contents of IF/ID and `epc` immediately, regardless of phase.

## Test plan
- **Reset and sequential run:** release `reset_n`, no controls asserted -> `imem_addr` = 0x80000000, 0x80000004, 0x80000008, …; `if_id_pc_plus4` trails by one cycle; `valid` = 1 from the first edge.
- **Branch vs jump collision:** at `pc` = 0x00400010, assert `branch_taken` (target 0x00400040) and `jump` (target 0x00400080) together -> next `pc` = 0x00400040; IF/ID gets a bubble (`valid` = 0, `instr` = 0).
- **Stall then release:** assert `stall` for 3 cycles at `pc` = 0x00400020 -> PC and IF/ID are frozen. After release -> `pc` = 0x00400024 and the word from 0x00400020 is captured exactly once.
- **Interrupt in user mode:** `pc` = 0x00400030, `irq` = 1 -> next `pc` = 0x80000004, `epc` = 0x00400034, `irq_ack` pulses once, IF/ID gets a bubble.
- **Masked and deferred interrupts:**
  - With `pc[31]` = 1, `irq` is ignored.
  - At `pc` = 0x00400030 with `jump` asserted (target 0x00400100) and `irq` held -> jump taken, with no interrupt on that cycle. On the next cycle at `pc` = 0x00400100 -> interrupt taken with `epc` = 0x00400104.
- **Exception over irq, and async reset:** `exception` and `irq` together -> `pc` = 0x80000008, `irq_ack` = 0. Then pull `reset_n` low between edges -> all outputs immediately return to their reset values.
